apb_master_requester: RTL

Synthesizable APB4 requester that drives the master end of the bus our slave-side BFMs respond to. It accepts one command at a time over a valid/ready interface, runs the SETUP/ACCESS sequence and honours `pready` wait states. It returns read data and status over a response valid/ready interface. A wait-state timeout keeps a hung slave from stalling the bus.

---
 rtl/apb_master_requester.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/apb_master_requester.sv
// APB4 requester: accepts one command over valid/ready, runs the SETUP/ACCESS
// handshake with wait states and an optional wait-state timeout, and returns
// read data and error status over a response valid/ready interface.
module apb_master_requester #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NO_OF_SLAVES   = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      pclk,
   input  logic                      preset_n,
   // command channel
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic                      cmd_write,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
   input  logic [2:0]                cmd_prot,
   input  logic [3:0]                cmd_slave_sel,
   // response channel
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_slverr,
   output logic                      rsp_timeout,
   // APB master port
   output logic [ADDR_WIDTH-1:0]     paddr,
   output logic [NO_OF_SLAVES-1:0]   psel,
   output logic                      penable,
   output logic                      pwrite,
   output logic [DATA_WIDTH-1:0]     pwdata,
   output logic [DATA_WIDTH/8-1:0]   pstrb,
   output logic [2:0]                pprot,
   input  logic                      pready,
   input  logic [DATA_WIDTH-1:0]     prdata,
   input  logic                      pslverr
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   // A zero timeout disables the counter; keep it one bit wide so it still elaborates.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [4:0]       NSLV     = 5'(NO_OF_SLAVES);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   logic [1:0]            state_q,       state_d;
   logic                  ready_q;
   logic [ADDR_WIDTH-1:0] paddr_q,       paddr_d;
   logic                  pwrite_q,      pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q,      pwdata_d;
   logic [STRB_WIDTH-1:0] pstrb_q,       pstrb_d;
   logic [2:0]            pprot_q,       pprot_d;
   logic [3:0]            sel_q,         sel_d;
   logic [CNT_W-1:0]      wait_cnt_q,    wait_cnt_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
   logic                  rsp_slverr_q,  rsp_slverr_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  bus_active;

   // Next-state and datapath decisions for the transfer sequence.
   always_comb begin
      state_d       = state_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      pprot_d       = pprot_q;
      sel_d         = sel_q;
      wait_cnt_d    = wait_cnt_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_slverr_d  = rsp_slverr_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && ready_q) begin
               if ({1'b0, cmd_slave_sel} < NSLV) begin
                  state_d    = ST_SETUP;
                  paddr_d    = cmd_addr;
                  pwrite_d   = cmd_write;
                  pwdata_d   = cmd_wdata;
                  pstrb_d    = cmd_write ? cmd_strb : '0;
                  pprot_d    = cmd_prot;
                  sel_d      = cmd_slave_sel;
                  wait_cnt_d = '0;
               end else begin
                  // Unknown slave: answer with an error without touching the bus.
                  state_d       = ST_RESP;
                  rsp_rdata_d   = '0;
                  rsp_slverr_d  = 1'b1;
                  rsp_timeout_d = 1'b0;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (pready) begin
               // A ready slave wins even in the cycle the timeout would fire.
               state_d       = ST_RESP;
               rsp_rdata_d   = pwrite_q ? '0 : prdata;
               rsp_slverr_d  = pslverr;
               rsp_timeout_d = 1'b0;
            end else begin
               if (wait_cnt_q != CNT_MAX) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
               if ((TIMEOUT_CYCLES > 0) && (wait_cnt_q == CNT_LAST)) begin
                  state_d       = ST_RESP;
                  rsp_rdata_d   = '0;
                  rsp_slverr_d  = 1'b1;
                  rsp_timeout_d = 1'b1;
               end
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and held bus/response registers; reset clears every visible output.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q       <= ST_IDLE;
         ready_q       <= 1'b0;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         pprot_q       <= '0;
         sel_q         <= '0;
         wait_cnt_q    <= '0;
         rsp_rdata_q   <= '0;
         rsp_slverr_q  <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ready_q       <= 1'b1;   // holds cmd_ready low until the first edge after reset
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         pprot_q       <= pprot_d;
         sel_q         <= sel_d;
         wait_cnt_q    <= wait_cnt_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_slverr_q  <= rsp_slverr_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

   // One select line per slave, decoded from the registered index.
   generate
      for (genvar gi = 0; gi < NO_OF_SLAVES; gi++) begin : g_psel
         assign psel[gi] = bus_active && (sel_q == 4'(gi));
      end
   endgenerate

   assign cmd_ready   = ready_q && (state_q == ST_IDLE);
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_slverr  = rsp_slverr_q;
   assign rsp_timeout = rsp_timeout_q;
   assign penable     = (state_q == ST_ACCESS);
   assign paddr       = paddr_q;
   assign pwrite      = pwrite_q;
   assign pwdata      = pwdata_q;
   assign pstrb       = pstrb_q;
   assign pprot       = pprot_q;

endmodule
